audio_mixer_nch: RTL and testbench

// - Parametrised N-channel audio mixer. Each channel is a signed PCM stream in memory with its own volume.
// - Fetches one sample per active channel and computes a volume-weighted sum.
// - Writes each mixed sample to a master output buffer.
// - Sits between the CPU register bus (slave) and the shared sample memory (single-master port). Raises irq_o when a mix run completes.

---
 rtl/audio_mixer_nch.sv | 278 +++++++++++++++++++++++++++
 tb/tb_audio_mixer_nch.sv | 424 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_mixer_nch.sv
// N-channel PCM mixer: fetches one sample per active channel, sums volume-weighted products and
// writes each mixed frame to a master buffer. Define AMIX_SAT_EN to clamp the output instead of wrapping.
module audio_mixer_nch #(
  parameter int N_CH     = 8,
  parameter int SAMPLE_W = 16,
  parameter int VOL_W    = 8,
  parameter int ADDR_W   = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                reg_stb_i,
  input  logic                reg_we_i,
  input  logic [7:0]          reg_addr_i,
  input  logic [31:0]         reg_dat_i,
  output logic [31:0]         reg_dat_o,
  output logic                reg_ack_o,
  output logic                mem_stb_o,
  output logic                mem_we_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [SAMPLE_W-1:0] mem_dat_o,
  input  logic [SAMPLE_W-1:0] mem_dat_i,
  input  logic                mem_ack_i,
  output logic                busy_o,
  output logic                irq_o
);

  localparam int IDX_W  = $clog2(N_CH + 1);
  localparam int TBL_W  = (IDX_W > 4) ? IDX_W : 4;
  localparam int TBL_N  = 1 << TBL_W;
  localparam int PROD_W = SAMPLE_W + VOL_W + 1;
  localparam int ACC_W  = SAMPLE_W + VOL_W + $clog2(N_CH) + 1;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SCAN    = 3'd1;
  localparam logic [2:0] S_RD_REQ  = 3'd2;
  localparam logic [2:0] S_RD_WAIT = 3'd3;
  localparam logic [2:0] S_MAC     = 3'd4;
  localparam logic [2:0] S_WR_REQ  = 3'd5;
  localparam logic [2:0] S_WR_WAIT = 3'd6;
  localparam logic [2:0] S_DONE    = 3'd7;

  logic [2:0]                state_reg;
  logic [IDX_W-1:0]          idx_reg;
  logic signed [ACC_W-1:0]   acc_reg;
  logic                      any_reg;
  logic                      done_reg;
  logic                      abort_pend_reg;
  logic [SAMPLE_W-1:0]       sample_reg;
  logic [ADDR_W-1:0]         rd_addr_reg;
  logic [ADDR_W-1:0]         master_addr_reg;
  logic [ADDR_W-1:0]         master_len_reg;

  logic [ADDR_W-1:0]         ch_addr [TBL_N];
  logic [ADDR_W-1:0]         ch_len  [TBL_N];
  logic [VOL_W-1:0]          ch_vol  [TBL_N];

  logic [TBL_W-1:0]          reg_sel;
  logic [TBL_W-1:0]          scan_sel;
  logic                      ch_wr_en;
  logic                      master_wr_en;
  logic                      ctrl_wr;
  logic                      start_cmd;
  logic                      abort_cmd;
  logic                      clr_cmd;
  logic                      scan_take;
  logic [31:0]               rd_data;
  logic signed [PROD_W-1:0]  prod;
  logic [SAMPLE_W-1:0]       out_word;

  assign busy_o   = (state_reg != S_IDLE);
  assign irq_o    = done_reg;
  assign reg_sel  = TBL_W'(reg_addr_i[6:3]);
  assign scan_sel = TBL_W'(idx_reg);

  assign ch_wr_en     = reg_stb_i & reg_we_i & reg_addr_i[7] & ~busy_o;
  assign master_wr_en = reg_stb_i & reg_we_i & ~reg_addr_i[7] & ~busy_o;
  assign ctrl_wr      = reg_stb_i & reg_we_i & (reg_addr_i == 8'h02);
  assign abort_cmd    = ctrl_wr & reg_dat_i[1];
  assign start_cmd    = ctrl_wr & reg_dat_i[0] & ~reg_dat_i[1] & (state_reg == S_IDLE);
  assign clr_cmd      = ctrl_wr & reg_dat_i[2];

  assign scan_take = (state_reg == S_SCAN) && !abort_cmd && (master_len_reg != '0) &&
                     (idx_reg != IDX_W'(N_CH)) && (ch_len[scan_sel] != '0);

  // Table is padded to a power of two so any index is in range; pad entries read as zero.
  for (genvar gi = 0; gi < TBL_N; gi++) begin : g_tbl
    if (gi < N_CH) begin : g_ch
      logic [ADDR_W-1:0] addr_reg;
      logic [ADDR_W-1:0] len_reg;
      logic [VOL_W-1:0]  vol_reg;

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          addr_reg <= '0;
          len_reg  <= '0;
          vol_reg  <= '0;
        end else if (ch_wr_en && (reg_sel == TBL_W'(gi))) begin
          case (reg_addr_i[2:0])
            3'd0:    addr_reg <= reg_dat_i[ADDR_W-1:0];
            3'd1:    len_reg  <= reg_dat_i[ADDR_W-1:0];
            3'd2:    vol_reg  <= reg_dat_i[VOL_W-1:0];
            default: ;
          endcase
        end else if (scan_take && (idx_reg == IDX_W'(gi))) begin
          addr_reg <= addr_reg + ADDR_W'(1);
          len_reg  <= len_reg - ADDR_W'(1);
        end
      end

      assign ch_addr[gi] = addr_reg;
      assign ch_len[gi]  = len_reg;
      assign ch_vol[gi]  = vol_reg;
    end else begin : g_pad
      assign ch_addr[gi] = '0;
      assign ch_len[gi]  = '0;
      assign ch_vol[gi]  = '0;
    end
  end

  always_comb begin
    rd_data = '0;
    if (reg_addr_i[7]) begin
      case (reg_addr_i[2:0])
        3'd0:    rd_data = 32'(ch_addr[reg_sel]);
        3'd1:    rd_data = 32'(ch_len[reg_sel]);
        3'd2:    rd_data = 32'(ch_vol[reg_sel]);
        default: ;
      endcase
    end else begin
      case (reg_addr_i[6:0])
        7'h00:   rd_data = 32'(master_addr_reg);
        7'h01:   rd_data = 32'(master_len_reg);
        7'h03:   rd_data = {30'd0, done_reg, busy_o};
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      reg_ack_o <= 1'b0;
      reg_dat_o <= '0;
    end else begin
      reg_ack_o <= reg_stb_i;
      reg_dat_o <= (reg_stb_i && !reg_we_i) ? rd_data : '0;
    end
  end

  // Volume is unsigned, so it gets a zero sign bit before the signed multiply.
  assign prod = PROD_W'($signed(sample_reg)) * PROD_W'($signed({1'b0, ch_vol[scan_sel]}));

`ifdef AMIX_SAT_EN
  localparam logic signed [ACC_W-1:0] OUT_MAX = ACC_W'((1 << (SAMPLE_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] OUT_MIN = ~OUT_MAX;
  logic signed [ACC_W-1:0] acc_sh;

  assign acc_sh = acc_reg >>> VOL_W;

  always_comb begin
    out_word = acc_sh[SAMPLE_W-1:0];
    if (acc_sh > OUT_MAX)
      out_word = {1'b0, {(SAMPLE_W-1){1'b1}}};
    else if (acc_sh < OUT_MIN)
      out_word = {1'b1, {(SAMPLE_W-1){1'b0}}};
  end
`else
  assign out_word = acc_reg[VOL_W +: SAMPLE_W];
`endif

  always_comb begin
    mem_stb_o  = 1'b0;
    mem_we_o   = 1'b0;
    mem_addr_o = '0;
    mem_dat_o  = '0;
    case (state_reg)
      S_RD_REQ, S_RD_WAIT: begin
        mem_stb_o  = 1'b1;
        mem_addr_o = rd_addr_reg;
      end
      S_WR_REQ, S_WR_WAIT: begin
        mem_stb_o  = 1'b1;
        mem_we_o   = 1'b1;
        mem_addr_o = master_addr_reg;
        mem_dat_o  = out_word;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg       <= S_IDLE;
      idx_reg         <= '0;
      acc_reg         <= '0;
      any_reg         <= 1'b0;
      done_reg        <= 1'b0;
      abort_pend_reg  <= 1'b0;
      sample_reg      <= '0;
      rd_addr_reg     <= '0;
      master_addr_reg <= '0;
      master_len_reg  <= '0;
    end else begin
      if (state_reg == S_DONE)
        done_reg <= 1'b1;
      else if (start_cmd || clr_cmd)
        done_reg <= 1'b0;

      if (master_wr_en && (reg_addr_i[6:0] == 7'h00))
        master_addr_reg <= reg_dat_i[ADDR_W-1:0];
      if (master_wr_en && (reg_addr_i[6:0] == 7'h01))
        master_len_reg <= reg_dat_i[ADDR_W-1:0];

      case (state_reg)
        S_IDLE: begin
          if (start_cmd) begin
            state_reg      <= S_SCAN;
            idx_reg        <= '0;
            acc_reg        <= '0;
            any_reg        <= 1'b0;
            abort_pend_reg <= 1'b0;
          end
        end
        S_SCAN: begin
          if (abort_cmd || (master_len_reg == '0))
            state_reg <= S_DONE;
          else if (idx_reg == IDX_W'(N_CH))
            state_reg <= any_reg ? S_WR_REQ : S_DONE;
          else if (ch_len[scan_sel] != '0) begin
            rd_addr_reg <= ch_addr[scan_sel];
            any_reg     <= 1'b1;
            state_reg   <= S_RD_REQ;
          end else
            idx_reg <= idx_reg + IDX_W'(1);
        end
        // A pending abort only takes effect once the outstanding bus cycle is acknowledged.
        S_RD_REQ, S_RD_WAIT: begin
          if (mem_ack_i) begin
            sample_reg <= mem_dat_i;
            state_reg  <= (abort_pend_reg || abort_cmd) ? S_DONE : S_MAC;
          end else begin
            state_reg <= S_RD_WAIT;
            if (abort_cmd)
              abort_pend_reg <= 1'b1;
          end
        end
        S_MAC: begin
          if (abort_cmd)
            state_reg <= S_DONE;
          else begin
            acc_reg   <= acc_reg + ACC_W'(prod);
            idx_reg   <= idx_reg + IDX_W'(1);
            state_reg <= S_SCAN;
          end
        end
        S_WR_REQ, S_WR_WAIT: begin
          if (mem_ack_i) begin
            master_addr_reg <= master_addr_reg + ADDR_W'(1);
            master_len_reg  <= master_len_reg - ADDR_W'(1);
            acc_reg         <= '0;
            idx_reg         <= '0;
            any_reg         <= 1'b0;
            state_reg       <= (abort_pend_reg || abort_cmd) ? S_DONE : S_SCAN;
          end else begin
            state_reg <= S_WR_WAIT;
            if (abort_cmd)
              abort_pend_reg <= 1'b1;
          end
        end
        S_DONE: begin
          state_reg      <= S_IDLE;
          abort_pend_reg <= 1'b0;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_audio_mixer_nch.sv
// Self-checking bench for audio_mixer_nch: directed scenarios plus randomized runs compared
// against a frame-level arithmetic model of the mixer.
module tb_audio_mixer_nch;
  localparam int N_CH     = 8;
  localparam int SAMPLE_W = 16;
  localparam int VOL_W    = 8;
  localparam int ADDR_W   = 32;

  logic                clk_i;
  logic                rst_i;
  logic                reg_stb_i;
  logic                reg_we_i;
  logic [7:0]          reg_addr_i;
  logic [31:0]         reg_dat_i;
  logic [31:0]         reg_dat_o;
  logic                reg_ack_o;
  logic                mem_stb_o;
  logic                mem_we_o;
  logic [ADDR_W-1:0]   mem_addr_o;
  logic [SAMPLE_W-1:0] mem_dat_o;
  logic [SAMPLE_W-1:0] mem_dat_i;
  logic                mem_ack_i;
  logic                busy_o;
  logic                irq_o;

  audio_mixer_nch #(.N_CH(N_CH), .SAMPLE_W(SAMPLE_W), .VOL_W(VOL_W), .ADDR_W(ADDR_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .reg_stb_i(reg_stb_i), .reg_we_i(reg_we_i), .reg_addr_i(reg_addr_i),
    .reg_dat_i(reg_dat_i), .reg_dat_o(reg_dat_o), .reg_ack_o(reg_ack_o),
    .mem_stb_o(mem_stb_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_dat_o(mem_dat_o), .mem_dat_i(mem_dat_i), .mem_ack_i(mem_ack_i),
    .busy_o(busy_o), .irq_o(irq_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  logic [15:0] mem [logic [31:0]];
  logic [31:0] wr_addr_q [$];
  logic [15:0] wr_data_q [$];
  int          rd_count;
  int          stb_cycles;
  int          stall_cycles;
  bit          stall_rand;

  logic [31:0] cfg_addr [N_CH];
  int          cfg_len  [N_CH];
  logic [7:0]  cfg_vol  [N_CH];

  logic [31:0] exp_addr_q [$];
  logic [15:0] exp_data_q [$];
  int          exp_len [N_CH];
  logic [31:0] exp_m_addr;
  logic [31:0] exp_m_len;

  function automatic logic [15:0] rd_mem(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return 16'h0000;
  endfunction

  function automatic logic [31:0] q_addr(input int i);
    if (i < wr_addr_q.size()) return wr_addr_q[i];
    return 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] q_data(input int i);
    if (i < wr_data_q.size()) return {16'h0000, wr_data_q[i]};
    return 32'hDEAD_BEEF;
  endfunction

  // Memory slave: acks after a configurable number of waiting cycles, records every write.
  initial begin : responder
    int wait_cnt;
    int lim;
    wait_cnt  = 0;
    lim       = 0;
    mem_ack_i = 1'b0;
    mem_dat_i = '0;
    forever begin
      @(negedge clk_i);
      mem_ack_i = 1'b0;
      if (rst_i || !mem_stb_o) begin
        wait_cnt = 0;
      end else begin
        stb_cycles++;
        if (wait_cnt == 0)
          lim = stall_rand ? int'($urandom_range(0, 2)) : stall_cycles;
        if (wait_cnt >= lim) begin
          mem_ack_i = 1'b1;
          if (mem_we_o) begin
            wr_addr_q.push_back(mem_addr_o);
            wr_data_q.push_back(mem_dat_o);
            mem[mem_addr_o] = mem_dat_o;
          end else begin
            rd_count++;
            mem_dat_i = rd_mem(mem_addr_o);
          end
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic reg_write(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk_i);
    reg_stb_i  = 1'b1;
    reg_we_i   = 1'b1;
    reg_addr_i = a;
    reg_dat_i  = d;
    @(negedge clk_i);
    reg_stb_i  = 1'b0;
    reg_we_i   = 1'b0;
  endtask

  task automatic reg_read(input logic [7:0] a, output logic [31:0] d, output logic ack);
    @(negedge clk_i);
    reg_stb_i  = 1'b1;
    reg_we_i   = 1'b0;
    reg_addr_i = a;
    @(negedge clk_i);
    reg_stb_i  = 1'b0;
    d   = reg_dat_o;
    ack = reg_ack_o;
  endtask

  task automatic read_chk(input string tag, input logic [7:0] a, input logic [31:0] exp);
    logic [31:0] d;
    logic        ack;
    reg_read(a, d, ack);
    check(tag, d, exp);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy_o && n < 3000) begin
      @(negedge clk_i);
      n++;
    end
    check(tag, {31'd0, busy_o}, 32'd0);
  endtask

  task automatic clear_cfg();
    for (int ch = 0; ch < N_CH; ch++) begin
      cfg_addr[ch] = '0;
      cfg_len[ch]  = 0;
      cfg_vol[ch]  = '0;
    end
  endtask

  task automatic program_cfg(input logic [31:0] m_addr, input logic [31:0] m_len);
    for (int ch = 0; ch < N_CH; ch++) begin
      reg_write({1'b1, 4'(ch), 3'd0}, cfg_addr[ch]);
      reg_write({1'b1, 4'(ch), 3'd1}, 32'(cfg_len[ch]));
      reg_write({1'b1, 4'(ch), 3'd2}, {24'd0, cfg_vol[ch]});
    end
    reg_write(8'h00, m_addr);
    reg_write(8'h01, m_len);
    wr_addr_q.delete();
    wr_data_q.delete();
    rd_count   = 0;
    stb_cycles = 0;
  endtask

  function automatic logic [15:0] out_of(input longint s);
    longint sh;
    sh = s >>> VOL_W;
`ifdef AMIX_SAT_EN
    if (sh > 32767) sh = 32767;
    if (sh < -32768) sh = -32768;
`endif
    return 16'(sh);
  endfunction

  // Frame-level model: every frame takes one sample from each channel with samples left.
  task automatic model_run(input logic [31:0] m_addr, input logic [31:0] m_len);
    logic [31:0] ptr [N_CH];
    int          rem [N_CH];
    longint      sum;
    bit          any;
    exp_addr_q.delete();
    exp_data_q.delete();
    for (int ch = 0; ch < N_CH; ch++) begin
      ptr[ch] = cfg_addr[ch];
      rem[ch] = cfg_len[ch];
    end
    while (m_len != 0) begin
      sum = 0;
      any = 0;
      for (int ch = 0; ch < N_CH; ch++) begin
        if (rem[ch] > 0) begin
          sum += longint'($signed(rd_mem(ptr[ch]))) * longint'(cfg_vol[ch]);
          ptr[ch] = ptr[ch] + 32'd1;
          rem[ch]--;
          any = 1;
        end
      end
      if (!any) break;
      exp_addr_q.push_back(m_addr);
      exp_data_q.push_back(out_of(sum));
      m_addr = m_addr + 32'd1;
      m_len  = m_len - 32'd1;
    end
    exp_m_addr = m_addr;
    exp_m_len  = m_len;
    for (int ch = 0; ch < N_CH; ch++) exp_len[ch] = rem[ch];
  endtask

  task automatic compare_model(input string tag);
    check($sformatf("%s nwr", tag), 32'(wr_addr_q.size()), 32'(exp_addr_q.size()));
    for (int i = 0; i < exp_addr_q.size(); i++) begin
      check($sformatf("%s wr%0d addr", tag, i), q_addr(i), exp_addr_q[i]);
      check($sformatf("%s wr%0d data", tag, i), q_data(i), {16'h0000, exp_data_q[i]});
    end
    read_chk($sformatf("%s mlen", tag), 8'h01, exp_m_len);
    read_chk($sformatf("%s maddr", tag), 8'h00, exp_m_addr);
    for (int ch = 0; ch < N_CH; ch++)
      read_chk($sformatf("%s ch%0d len", tag, ch), {1'b1, 4'(ch), 3'd1}, 32'(exp_len[ch]));
    check($sformatf("%s irq", tag), {31'd0, irq_o}, 32'd1);
  endtask

  initial begin : stim
    logic [31:0] d;
    logic        ack;
    logic [31:0] a0;
    logic [31:0] m_addr;
    logic [31:0] m_len;
    int          n;

    rst_i = 1'b0; reg_stb_i = 1'b0; reg_we_i = 1'b0; reg_addr_i = '0; reg_dat_i = '0;
    stall_cycles = 0; stall_rand = 0; rd_count = 0; stb_cycles = 0;
    clear_cfg();
    #1 rst_i = 1'b1;
    repeat (3) @(negedge clk_i);
    check("rst outs", {mem_addr_o[15:0], mem_dat_o[11:0], mem_stb_o, mem_we_o, busy_o, irq_o},
          32'd0);
    check("rst reg out", reg_dat_o | {31'd0, reg_ack_o}, 32'd0);
    rst_i = 1'b0;
    reg_read(8'h03, d, ack);
    check("rst status", d, 32'd0);
    check("ack pulse", {31'd0, ack}, 32'd1);
    @(negedge clk_i);
    check("ack one cycle", {31'd0, reg_ack_o}, 32'd0);

    // One channel, spec vector.
    clear_cfg();
    cfg_addr[0] = 32'h100; cfg_len[0] = 3; cfg_vol[0] = 8'd255;
    mem[32'h100] = 16'h1000; mem[32'h101] = 16'hF000; mem[32'h102] = 16'h0001;
    program_cfg(32'h800, 32'd3);
    reg_write(8'h02, 32'h1);
    wait_idle("A idle");
    check("A nwr", 32'(wr_addr_q.size()), 32'd3);
    check("A wr0 addr", q_addr(0), 32'h800);
    check("A wr0 data", q_data(0), 32'h0FF0);
    check("A wr1 addr", q_addr(1), 32'h801);
    check("A wr1 data", q_data(1), 32'hF010);
    check("A wr2 addr", q_addr(2), 32'h802);
    check("A wr2 data", q_data(2), 32'h0000);
    check("A irq", {31'd0, irq_o}, 32'd1);
    read_chk("A ch0 len", 8'h81, 32'd0);
    read_chk("A ch0 addr", 8'h80, 32'h103);
    read_chk("A status", 8'h03, 32'h2);
    reg_write(8'h02, 32'h4);

    // Two full-scale channels: wraps or saturates.
    clear_cfg();
    cfg_addr[0] = 32'h200; cfg_len[0] = 1; cfg_vol[0] = 8'd255;
    cfg_addr[1] = 32'h300; cfg_len[1] = 1; cfg_vol[1] = 8'd255;
    mem[32'h200] = 16'h7000; mem[32'h300] = 16'h7000;
    program_cfg(32'h900, 32'd1);
    reg_write(8'h02, 32'h1);
    wait_idle("B idle");
    check("B nwr", 32'(wr_addr_q.size()), 32'd1);
`ifdef AMIX_SAT_EN
    check("B mixed", q_data(0), 32'h7FFF);
`else
    check("B mixed", q_data(0), 32'hDF20);
`endif
    reg_write(8'h02, 32'h4);

    // Uneven lengths; out-of-range channel write is ignored.
    clear_cfg();
    cfg_addr[0] = 32'h400; cfg_len[0] = 2; cfg_vol[0] = 8'd128;
    cfg_addr[3] = 32'h500; cfg_len[3] = 4; cfg_vol[3] = 8'd200;
    for (int i = 0; i < 4; i++) begin
      mem[32'h400 + 32'(i)] = 16'($urandom);
      mem[32'h500 + 32'(i)] = 16'($urandom);
    end
    program_cfg(32'hA000, 32'd10);
    reg_write(8'hC1, 32'd7);
    read_chk("C ch8 len", 8'hC1, 32'd0);
    model_run(32'hA000, 32'd10);
    reg_write(8'h02, 32'h1);
    wait_idle("C idle");
    check("C frame3 ch3 only", q_data(2),
          {16'h0000, out_of(longint'($signed(mem[32'h502])) * 200)});
    compare_model("C");
    read_chk("C mlen 6", 8'h01, 32'd6);
    reg_write(8'h02, 32'h4);

    // Stalled read with abort during the stall.
    clear_cfg();
    cfg_addr[2] = 32'h600; cfg_len[2] = 1; cfg_vol[2] = 8'd100;
    mem[32'h600] = 16'h1234;
    program_cfg(32'hB00, 32'd1);
    stall_cycles = 8;
    reg_write(8'h02, 32'h1);
    n = 0;
    while (!mem_stb_o && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    check("D stb seen", {31'd0, mem_stb_o}, 32'd1);
    a0 = mem_addr_o;
    check("D rd addr", a0, 32'h600);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      check($sformatf("D stall%0d stb", i), {31'd0, mem_stb_o, mem_we_o}, 32'h2);
      check($sformatf("D stall%0d addr", i), mem_addr_o, a0);
    end
    reg_write(8'h02, 32'h2);
    check("D stb held after abort", {31'd0, mem_stb_o}, 32'd1);
    wait_idle("D idle");
    stall_cycles = 0;
    check("D reads", 32'(rd_count), 32'd1);
    check("D writes", 32'(wr_addr_q.size()), 32'd0);
    check("D irq", {31'd0, irq_o}, 32'd1);
    read_chk("D mlen", 8'h01, 32'd1);
    reg_write(8'h02, 32'h4);

    // Master len zero, then all channel lens zero.
    clear_cfg();
    cfg_addr[0] = 32'h100; cfg_len[0] = 2; cfg_vol[0] = 8'd1;
    program_cfg(32'hC00, 32'd0);
    reg_write(8'h02, 32'h1);
    wait_idle("E1 idle");
    check("E1 no stb", 32'(stb_cycles), 32'd0);
    check("E1 irq", {31'd0, irq_o}, 32'd1);
    read_chk("E1 ch0 len", 8'h81, 32'd2);
    reg_write(8'h02, 32'h4);
    check("E1 irq cleared", {31'd0, irq_o}, 32'd0);
    clear_cfg();
    program_cfg(32'hC00, 32'd5);
    reg_write(8'h02, 32'h1);
    wait_idle("E2 idle");
    check("E2 no stb", 32'(stb_cycles), 32'd0);
    check("E2 irq", {31'd0, irq_o}, 32'd1);
    read_chk("E2 mlen", 8'h01, 32'd5);
    reg_write(8'h02, 32'h4);
    check("E2 irq cleared", {31'd0, irq_o}, 32'd0);
    reg_write(8'h02, 32'h3);
    check("E3 start+abort busy", {31'd0, busy_o}, 32'd0);
    @(negedge clk_i);
    check("E3 start+abort irq", {31'd0, irq_o}, 32'd0);

    // Randomized runs against the model.
    stall_rand = 1;
    for (int it = 0; it < 6; it++) begin
      for (int ch = 0; ch < N_CH; ch++) begin
        cfg_len[ch]  = int'($urandom_range(0, 3));
        cfg_addr[ch] = 32'h1000 * 32'(ch + 1) + 32'($urandom_range(0, 255));
        cfg_vol[ch]  = 8'($urandom);
      end
      if (it == 0) begin
        cfg_addr[7] = 32'hFFFF_FFFF;
        cfg_len[7]  = 3;
      end
      for (int ch = 0; ch < N_CH; ch++)
        for (int i = 0; i < cfg_len[ch]; i++)
          mem[cfg_addr[ch] + 32'(i)] = 16'($urandom);
      m_addr = 32'h8000_0000 + 32'($urandom_range(0, 32'hFFF));
      m_len  = 32'($urandom_range(0, 5));
      program_cfg(m_addr, m_len);
      model_run(m_addr, m_len);
      reg_write(8'h02, 32'h1);
      wait_idle($sformatf("R%0d idle", it));
      compare_model($sformatf("R%0d", it));
      reg_write(8'h02, 32'h4);
    end
    stall_rand = 0;

    // Reset in the middle of a stalled read.
    clear_cfg();
    cfg_addr[0] = 32'h100; cfg_len[0] = 2; cfg_vol[0] = 8'd10;
    program_cfg(32'hD00, 32'd2);
    stall_cycles = 1000;
    reg_write(8'h02, 32'h1);
    n = 0;
    while (!mem_stb_o && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    check("G stb before rst", {31'd0, mem_stb_o}, 32'd1);
    @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    check("G stb/we", {30'd0, mem_stb_o, mem_we_o}, 32'd0);
    check("G mem addr", mem_addr_o, 32'd0);
    check("G busy/irq", {30'd0, busy_o, irq_o}, 32'd0);
    check("G reg out", reg_dat_o | {31'd0, reg_ack_o}, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    stall_cycles = 0;
    read_chk("G status", 8'h03, 32'd0);
    read_chk("G ch0 len", 8'h81, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
